// File: rtl/xrv_pkg.sv
// Shared types for the xrv memory arbiter: FSM state encoding and default fairness limit.
package xrv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_I    = 2'd1,
    GNT_D_RD = 2'd2,
    GNT_D_WR = 2'd3
  } xrv_arb_state_t;

  localparam int FAIR_LIMIT_DEF = 4;

endpackage

// File: rtl/xrv_mem_arb_if.sv
// Fetch, data and memory-side buses of the arbiter; slave = arbiter view, master = environment view.
interface xrv_mem_arb_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rd_data;

  logic [31:0] d_addr;
  logic        d_wr_req;
  logic [3:0]  d_be;
  logic [31:0] d_wr_data;
  logic        d_wr_ready;
  logic        d_rd_req;
  logic        d_rd_ready;
  logic [31:0] d_rd_data;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_ready, i_rd_data,
    input  d_addr, d_wr_req, d_be, d_wr_data, d_rd_req,
    output d_wr_ready, d_rd_ready, d_rd_data,
    output m_req, m_we, m_addr, m_be, m_wdata,
    input  m_ready, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ready, i_rd_data,
    output d_addr, d_wr_req, d_be, d_wr_data, d_rd_req,
    input  d_wr_ready, d_rd_ready, d_rd_data,
    input  m_req, m_we, m_addr, m_be, m_wdata,
    output m_ready, m_rdata
  );

endinterface

// File: rtl/xrv_mem_arb.sv
// Fetch/data arbiter onto one memory port: 1-cycle arbitration, no preemption, always via IDLE.
// Data wins unless fetch has been starved FAIR_LIMIT grants; ready is routed from m_ready.
module xrv_mem_arb
  import xrv_pkg::*;
#(
  parameter int FAIR_LIMIT = FAIR_LIMIT_DEF
) (
  input  logic           clk,
  input  logic           rstb,
  xrv_mem_arb_if.slave   bus,
  output logic           arb_busy
);

  localparam logic [3:0] L_FAIR = 4'(FAIR_LIMIT);

  xrv_arb_state_t r_state;
  xrv_arb_state_t w_state_nxt;
  logic [3:0]     r_starve;
  logic [3:0]     w_starve_nxt;
  logic           w_d_any;
  logic           w_fetch_win;

  assign w_d_any     = bus.d_wr_req | bus.d_rd_req;
  assign w_fetch_win = bus.i_req & (~w_d_any | (r_starve == L_FAIR));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state  <= IDLE;
      r_starve <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    case (r_state)
      IDLE: begin
        if (w_fetch_win) begin
          w_state_nxt  = GNT_I;
          w_starve_nxt = 4'd0;
        end else if (w_d_any) begin
          // Write wins a simultaneous read; the read simply stays pending.
          w_state_nxt = bus.d_wr_req ? GNT_D_WR : GNT_D_RD;
          if (!bus.i_req)
            w_starve_nxt = 4'd0;
          else if (r_starve >= L_FAIR)
            w_starve_nxt = L_FAIR;
          else
            w_starve_nxt = r_starve + 4'd1;
        end
      end
      default: begin
        if (bus.m_ready)
          w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.m_req      = (r_state != IDLE);
  assign bus.m_we       = (r_state == GNT_D_WR);
  assign bus.m_addr     = (r_state == GNT_I) ? bus.i_addr : bus.d_addr;
  assign bus.m_be       = (r_state == GNT_I) ? 4'hf : bus.d_be;
  assign bus.m_wdata    = bus.d_wr_data;

  assign bus.i_ready    = bus.m_ready & (r_state == GNT_I);
  assign bus.d_rd_ready = bus.m_ready & (r_state == GNT_D_RD);
  assign bus.d_wr_ready = bus.m_ready & (r_state == GNT_D_WR);
  assign bus.i_rd_data  = bus.m_rdata;
  assign bus.d_rd_data  = bus.m_rdata;

  assign arb_busy       = (r_state != IDLE);

endmodule
